fb_draw_scheduler: RTL
======================

# fb_draw_scheduler

Frame-rate scheduler owning the single frame-buffer write port of the VGA drawing path. Once per frame it sequences up to three drawing engines (background clear, waveform, optional overlay) by handing each an exclusive lock, forwarding that engine's pixel writes to the frame buffer, and advancing on the engine's done pulse or a per-phase watchdog. It sits between the drawing engines and the frame-buffer write port.

## Interface
- FRAME_CYCLES, 500000: clk cycles per frame period (50 Hz at 25 MHz); must be ≥ 8
- MAX_PHASE_CYCLES, 200000: watchdog limit per phase, in cycles; must be ≥ 2
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- overlay_en  in  1  1 = run OVERLAY phase; sampled at frame start
- err_clr  in  1  clears sticky error bits
- eng_x  in  24  engine X coords; engine i occupies bits [8i+7:8i] (0 = clear, 1 = wave, 2 = overlay)
- eng_y  in  24  engine Y coords, same packing
- eng_color  in  36  engine colors; engine i occupies bits [12i+11:12i]
- eng_we  in  3  per-engine pixel write strobe
- eng_done  in  3  per-engine completion pulse
- lock  out  3  one-hot engine grant; 000 when no phase is active
- CounterX  out  8  frame-buffer write X
- CounterY  out  8  frame-buffer write Y
- color  out  12  frame-buffer write color (4:4:4 RGB)
- we  out  1  frame-buffer write strobe
- phase  out  2  0 idle, 1 clear, 2 wave, 3 overlay
- frame_done  out  1  one-cycle pulse when the sequence completes
- timeout_err  out  3  sticky per-engine watchdog flags
- overrun_err  out  1  sticky flag: frame tick arrived while the sequence was still running

## Operation
- Frame counter k counts 0..FRAME_CYCLES-1 and wraps. The tick is the cycle in which k == FRAME_CYCLES-1.
- States: IDLE, CLEAR, GAP1, WAVE, GAP2, OVERLAY, DONE.
- IDLE: on tick, latch overlay_en and go to CLEAR.
- CLEAR: when eng_done[0] is seen or the watchdog expires, go to GAP1.
- GAP1: lasts one cycle, then go to WAVE.
- WAVE: on done or watchdog expiry, go to GAP2 if latched overlay_en = 1, else go to DONE.
- GAP2: lasts one cycle, then go to OVERLAY.
- OVERLAY: on done or watchdog expiry, go to DONE.
- DONE: lasts one cycle; frame_done = 1; then go to IDLE.
- lock is a combinational decode of the state register: 001 in CLEAR, 010 in WAVE, 100 in OVERLAY, 000 in every other state. The GAP states guarantee each engine sees lock low for at least one cycle between grants.
- Phase cycle counter:
  - resets to 0 on entry to each locked state;
  - increments each cycle in that state;
  - when it reaches MAX_PHASE_CYCLES-1 without done, the phase ends as if done arrived, and timeout_err[i] is set.
- eng_done[i] is ignored unless lock[i] = 1. eng_we from an engine without the lock is ignored.
- Write port: if lock[i] = 1 and eng_we[i] = 1 at cycle t, then at t+1 we = 1 and CounterX/CounterY/color take engine i's fields. Otherwise we = 0 and the coordinate/color outputs hold.
- A write and done in the same cycle: the write is forwarded, and the phase ends.
- Tick while not IDLE: overrun_err is set, the tick is dropped, and the running sequence continues unaffected. No restart occurs until the next tick seen in IDLE.
- Sticky errors:
  - err_clr = 1 clears timeout_err and overrun_err next cycle.
  - If a set event and err_clr coincide, the set wins.
- Arithmetic: k width = clog2(FRAME_CYCLES); phase counter width = clog2(MAX_PHASE_CYCLES). Both are unsigned and never exceed their limit.

## Timing
- Reset values:
  - state = IDLE; k = 0; phase counter = 0;
  - lock = 000, CounterX = 0, CounterY = 0, color = 0, we = 0;
  - phase = 0, frame_done = 0, timeout_err = 000, overrun_err = 0.
- Reset asserted mid-sequence: on the next edge all of the above apply, lock drops immediately, and no further writes are forwarded.
- Tick at cycle t: state = CLEAR and lock = 001 at t+1.
- Done at cycle t in CLEAR: lock = 000 at t+1 (GAP1), lock = 010 at t+2.
- Pixel write latency is exactly 1 cycle. Throughput is one write per cycle while locked.
- frame_done rises 1 cycle after the final phase ends and lasts 1 cycle.
- The first tick after reset occurs at cycle FRAME_CYCLES-1, counting from the first cycle with rst = 0.

## Test plan
- FRAME_CYCLES = 64, MAX_PHASE_CYCLES = 16, overlay_en = 1; each engine pulses done 5 cycles after its lock rises. Required:
  - phase sequence 1, 0, 2, 0, 3, 0;
  - lock gaps of exactly 1 cycle;
  - frame_done 1 cycle after the overlay done;
  - no errors.
- Clear engine writes x = 0x12, y = 0x34, color = 0xABC while locked, and the wave engine writes simultaneously without the lock. Required: next cycle we = 1 with 0x12/0x34/0xABC; the wave write is never forwarded.
- Clear engine never asserts done. Required: CLEAR ends after 16 cycles, timeout_err = 001, and WAVE proceeds normally.
- overlay_en = 0 at tick. Required: the sequence goes WAVE → DONE, lock[2] is never asserted, and overlay_en toggling mid-frame has no effect.
- Engines hold done off for 70 cycles with MAX_PHASE_CYCLES = 100. Required: overrun_err = 1 at the next tick and no restart. After err_clr, overrun_err = 0.
- rst asserted while lock = 010 with eng_we active. Required: next cycle lock = 000, we = 0, all outputs at reset values; the first new CLEAR starts at the 64th cycle after reset release.

Source files
------------

// File: rtl/fb_draw_scheduler_if.sv
// Engine-side and frame-buffer-side signals of the draw scheduler.
// master: the scheduler itself. slave: the engines, frame buffer and control
// logic that surround it.
interface fb_draw_scheduler_if;
  logic        overlay_en;
  logic        err_clr;
  logic [23:0] eng_x;
  logic [23:0] eng_y;
  logic [35:0] eng_color;
  logic [2:0]  eng_we;
  logic [2:0]  eng_done;
  logic [2:0]  lock;
  logic [7:0]  CounterX;
  logic [7:0]  CounterY;
  logic [11:0] color;
  logic        we;
  logic [1:0]  phase;
  logic        frame_done;
  logic [2:0]  timeout_err;
  logic        overrun_err;

  modport master (
    input  overlay_en, err_clr, eng_x, eng_y, eng_color, eng_we, eng_done,
    output lock, CounterX, CounterY, color, we, phase, frame_done,
           timeout_err, overrun_err
  );

  modport slave (
    output overlay_en, err_clr, eng_x, eng_y, eng_color, eng_we, eng_done,
    input  lock, CounterX, CounterY, color, we, phase, frame_done,
           timeout_err, overrun_err
  );
endinterface

// File: rtl/fb_draw_scheduler.sv
// Frame-rate scheduler owning the frame-buffer write port. Each frame it grants
// the port to the clear, wave and (optionally) overlay engines in turn, with a
// one-cycle dead gap between grants, a per-phase watchdog and sticky errors.
module fb_draw_scheduler #(
  parameter int FRAME_CYCLES     = 500000,
  parameter int MAX_PHASE_CYCLES = 200000
) (
  input  logic                  clk,
  input  logic                  rst,
  fb_draw_scheduler_if.master   bus
);

  localparam int KW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam int PW = (MAX_PHASE_CYCLES > 1) ? $clog2(MAX_PHASE_CYCLES) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(FRAME_CYCLES - 1);
  localparam logic [PW-1:0] P_LAST = PW'(MAX_PHASE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_GAP1, S_WAVE, S_GAP2, S_OVERLAY, S_DONE
  } state_t;

  state_t          r_state;
  logic [KW-1:0]   r_k;
  logic [PW-1:0]   r_cnt;
  logic            r_ovl_en;
  logic [7:0]      r_x;
  logic [7:0]      r_y;
  logic [11:0]     r_color;
  logic            r_we;
  logic [2:0]      r_tmo;
  logic            r_ovr;

  logic            w_tick;
  logic [2:0]      w_lock;
  logic [1:0]      w_phase;
  logic            w_frame_done;
  logic            w_locked;
  logic            w_done_act;
  logic            w_wd;
  logic            w_end;
  logic            w_expire;
  logic            w_sel_we;
  logic [7:0]      w_sel_x;
  logic [7:0]      w_sel_y;
  logic [11:0]     w_sel_color;

  assign w_tick     = (r_k == K_LAST);
  assign w_locked   = |w_lock;
  // Done from an engine without the grant is masked here.
  assign w_done_act = |(w_lock & bus.eng_done);
  assign w_wd       = w_locked && (r_cnt == P_LAST);
  assign w_end      = w_done_act || w_wd;
  assign w_expire   = w_wd && !w_done_act;

  // Grant, phase code and frame_done decoded straight from the state register.
  always_comb begin
    w_lock       = 3'b000;
    w_phase      = 2'd0;
    w_frame_done = 1'b0;
    case (r_state)
      S_CLEAR:   begin w_lock = 3'b001; w_phase = 2'd1; end
      S_WAVE:    begin w_lock = 3'b010; w_phase = 2'd2; end
      S_OVERLAY: begin w_lock = 3'b100; w_phase = 2'd3; end
      S_DONE:    w_frame_done = 1'b1;
      default:   ;
    endcase
  end

  // Select the write fields of whichever engine currently holds the grant.
  always_comb begin
    w_sel_we    = 1'b0;
    w_sel_x     = 8'd0;
    w_sel_y     = 8'd0;
    w_sel_color = 12'd0;
    for (int i = 0; i < 3; i++) begin
      if (w_lock[i]) begin
        w_sel_we    = bus.eng_we[i];
        w_sel_x     = bus.eng_x[8*i +: 8];
        w_sel_y     = bus.eng_y[8*i +: 8];
        w_sel_color = bus.eng_color[12*i +: 12];
      end
    end
  end

  // Free-running frame counter; the tick is its last count.
  always_ff @(posedge clk) begin
    if (rst)         r_k <= '0;
    else if (w_tick) r_k <= '0;
    else             r_k <= r_k + KW'(1);
  end

  // Phase sequencer plus the watchdog counter, which only runs inside a grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_ovl_en <= 1'b0;
    end else begin
      r_cnt <= (w_locked && !w_end) ? r_cnt + PW'(1) : '0;
      case (r_state)
        S_IDLE: if (w_tick) begin
          r_ovl_en <= bus.overlay_en;
          r_state  <= S_CLEAR;
        end
        S_CLEAR:   if (w_end) r_state <= S_GAP1;
        S_GAP1:    r_state <= S_WAVE;
        S_WAVE:    if (w_end) r_state <= r_ovl_en ? S_GAP2 : S_DONE;
        S_GAP2:    r_state <= S_OVERLAY;
        S_OVERLAY: if (w_end) r_state <= S_DONE;
        S_DONE:    r_state <= S_IDLE;
        default:   r_state <= S_IDLE;
      endcase
    end
  end

  // Sticky error flags; a new error event beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tmo <= 3'b000;
      r_ovr <= 1'b0;
    end else begin
      r_tmo <= (bus.err_clr ? 3'b000 : r_tmo) | (w_expire ? w_lock : 3'b000);
      r_ovr <= (bus.err_clr ? 1'b0 : r_ovr) | (w_tick && (r_state != S_IDLE));
    end
  end

  // Registered write port: one-cycle latency, fields hold when no write.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_we    <= 1'b0;
      r_x     <= 8'd0;
      r_y     <= 8'd0;
      r_color <= 12'd0;
    end else begin
      r_we <= w_sel_we;
      if (w_sel_we) begin
        r_x     <= w_sel_x;
        r_y     <= w_sel_y;
        r_color <= w_sel_color;
      end
    end
  end

  assign bus.lock        = w_lock;
  assign bus.phase       = w_phase;
  assign bus.frame_done  = w_frame_done;
  assign bus.we          = r_we;
  assign bus.CounterX    = r_x;
  assign bus.CounterY    = r_y;
  assign bus.color       = r_color;
  assign bus.timeout_err = r_tmo;
  assign bus.overrun_err = r_ovr;

endmodule
